// File: rtl/keypad_display_arbiter_if.sv
// Handshake bundle between the keypad/display arbiter and its surroundings:
// the operational controller, the setup controller, the keypad decoder and
// the six-digit display. The master side drives requests and keypad packets,
// and the slave side (the arbiter) drives the routed outputs.
interface keypad_display_arbiter_if #(
    parameter int PAC_W = 80
);
    logic             setup_req;
    logic             setup_done;
    logic             op_teclado_en;
    logic             kp_valid;
    logic [PAC_W-1:0] kp_value;
    logic             op_disp_en;
    logic             setup_disp_en;
    logic             kp_enable;
    logic [PAC_W-1:0] dig_value;
    logic             op_valid;
    logic             setup_valid;
    logic             disp_en_o;
    logic             disp_en_s;
    logic             owner;
    logic             setup_abort;

    modport master (
        output setup_req, setup_done, op_teclado_en, kp_valid, kp_value,
               op_disp_en, setup_disp_en,
        input  kp_enable, dig_value, op_valid, setup_valid, disp_en_o,
               disp_en_s, owner, setup_abort
    );

    modport slave (
        input  setup_req, setup_done, op_teclado_en, kp_valid, kp_value,
               op_disp_en, setup_disp_en,
        output kp_enable, dig_value, op_valid, setup_valid, disp_en_o,
               disp_en_s, owner, setup_abort
    );
endinterface

// File: rtl/keypad_display_arbiter.sv
// Keypad/display ownership arbiter for the lock.
// One controller at a time (operational or setup) owns the keypad packets and
// the display. Every ownership change passes through a flush window with the
// keypad disabled so that no stale packet reaches the new owner. A setup
// session with no keypad activity for SETUP_TIMEOUT cycles is forced back to
// operational and reported with a one-cycle setup_abort pulse.
module keypad_display_arbiter #(
    parameter int PAC_W         = 80,
    parameter int FLUSH_CYCLES  = 16,
    parameter int SETUP_TIMEOUT = 30_000_000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    keypad_display_arbiter_if.slave  bus
);

    // A single-cycle flush still needs a one-bit counter.
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int TW = $clog2(SETUP_TIMEOUT);

    localparam logic [FW-1:0] FLUSH_LAST   = FW'(FLUSH_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(SETUP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_OP       = 2'd0,
        ST_TO_SETUP = 2'd1,
        ST_SETUP    = 2'd2,
        ST_TO_OP    = 2'd3
    } state_t;

    state_t           r_state;
    logic [FW-1:0]    r_flush_cnt;
    logic [TW-1:0]    r_idle_cnt;
    logic [PAC_W-1:0] r_dig_value;
    logic             r_op_valid;
    logic             r_setup_valid;
    logic             r_setup_abort;

    state_t           w_state_nxt;
    logic [FW-1:0]    w_flush_nxt;
    logic [TW-1:0]    w_idle_nxt;
    logic             w_abort_nxt;
    logic             w_kp_enable;
    logic             w_disp_en_o;
    logic             w_disp_en_s;
    logic             w_owner;
    logic             w_route_ok;

    // Next-state, counter updates and state-decoded enables.
    always_comb begin
        w_state_nxt = r_state;
        w_flush_nxt = r_flush_cnt;
        w_idle_nxt  = r_idle_cnt;
        w_abort_nxt = 1'b0;
        w_kp_enable = 1'b0;
        w_disp_en_o = 1'b0;
        w_disp_en_s = 1'b0;
        w_owner     = 1'b0;
        case (r_state)
            ST_OP: begin
                w_kp_enable = bus.op_teclado_en;
                w_disp_en_o = bus.op_disp_en;
                if (bus.setup_req) begin
                    w_state_nxt = ST_TO_SETUP;
                    w_flush_nxt = {FW{1'b0}};
                end else begin
                    w_flush_nxt = {FW{1'b0}};
                end
            end
            ST_TO_SETUP: begin
                w_owner = 1'b1;
                if (r_flush_cnt == FLUSH_LAST) begin
                    w_state_nxt = ST_SETUP;
                    w_idle_nxt  = {TW{1'b0}};
                end else if (!bus.setup_req) begin
                    w_state_nxt = ST_TO_OP;
                    w_flush_nxt = {FW{1'b0}};
                end else begin
                    w_flush_nxt = r_flush_cnt + 1'b1;
                end
            end
            ST_SETUP: begin
                w_kp_enable = 1'b1;
                w_disp_en_s = bus.setup_disp_en;
                w_owner     = 1'b1;
                // Any keypad packet restarts the inactivity window; the
                // counter never wraps because the state is left at its top.
                if (bus.kp_valid) begin
                    w_idle_nxt = {TW{1'b0}};
                end else if (r_idle_cnt != TIMEOUT_LAST) begin
                    w_idle_nxt = r_idle_cnt + 1'b1;
                end else begin
                    w_idle_nxt = r_idle_cnt;
                end
                // A committed configuration wins over a coincident timeout.
                if (bus.setup_done) begin
                    w_state_nxt = ST_TO_OP;
                    w_flush_nxt = {FW{1'b0}};
                end else if (r_idle_cnt == TIMEOUT_LAST) begin
                    w_abort_nxt = 1'b1;
                    w_state_nxt = ST_TO_OP;
                    w_flush_nxt = {FW{1'b0}};
                end else if (!bus.setup_req) begin
                    w_state_nxt = ST_TO_OP;
                    w_flush_nxt = {FW{1'b0}};
                end else begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_TO_OP: begin
                // The flush count saturates while setup_req is still high,
                // so the exit happens on the first cycle it is released.
                if ((r_flush_cnt >= FLUSH_LAST) && !bus.setup_req) begin
                    w_state_nxt = ST_OP;
                    w_flush_nxt = {FW{1'b0}};
                end else if (r_flush_cnt != FLUSH_LAST) begin
                    w_flush_nxt = r_flush_cnt + 1'b1;
                end else begin
                    w_flush_nxt = r_flush_cnt;
                end
            end
            default: begin
                w_state_nxt = ST_OP;
                w_flush_nxt = {FW{1'b0}};
                w_idle_nxt  = {TW{1'b0}};
            end
        endcase
    end

    // Packets are routed by the current owner, never by the next one.
    always_comb begin
        if ((r_state == ST_OP) || (r_state == ST_SETUP)) begin
            w_route_ok = bus.kp_valid;
        end else begin
            w_route_ok = 1'b0;
        end
    end

    // State, counters and registered routing outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state       <= ST_OP;
            r_flush_cnt   <= {FW{1'b0}};
            r_idle_cnt    <= {TW{1'b0}};
            r_dig_value   <= {PAC_W{1'b0}};
            r_op_valid    <= 1'b0;
            r_setup_valid <= 1'b0;
            r_setup_abort <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_flush_cnt   <= w_flush_nxt;
            r_idle_cnt    <= w_idle_nxt;
            r_op_valid    <= bus.kp_valid && (r_state == ST_OP);
            r_setup_valid <= bus.kp_valid && (r_state == ST_SETUP);
            r_setup_abort <= w_abort_nxt;
            if (w_route_ok) begin
                r_dig_value <= bus.kp_value;
            end
        end
    end

    assign bus.kp_enable   = w_kp_enable;
    assign bus.disp_en_o   = w_disp_en_o;
    assign bus.disp_en_s   = w_disp_en_s;
    assign bus.owner       = w_owner;
    assign bus.dig_value   = r_dig_value;
    assign bus.op_valid    = r_op_valid;
    assign bus.setup_valid = r_setup_valid;
    assign bus.setup_abort = r_setup_abort;

endmodule
